// File: rtl/vec_lane_sequencer_if.sv
// Decode/ALU-side handshake and beat bus for vec_lane_sequencer; vmask exists only with VEC_LANE_SEQ_MASK_EN.
// master = decode/writeback side driving start, config and beat_ready; slave = the sequencer.
interface vec_lane_sequencer_if #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int MAX_LANES  = 4
);
  localparam int IDXW = $clog2(VLEN);
  localparam int VLW  = $clog2(VLEN / 8) + 1;
  localparam int LNW  = ($clog2(MAX_LANES) + 1 > 1) ? $clog2(MAX_LANES) + 1 : 1;

  logic                      start;
  logic [LNW-1:0]            nb_lanes;
  logic [2:0]                vsew;
  logic [VLW-1:0]            vl;
  logic                      busy;
  logic                      beat_valid;
  logic                      beat_ready;
  logic [MAX_LANES-1:0]      lane_en;
  logic [MAX_LANES*IDXW-1:0] bit_idx;
  logic [3:0]                chunk_off;
  logic                      done;
  logic                      err;
`ifdef VEC_LANE_SEQ_MASK_EN
  logic [VLEN/8-1:0]         vmask;

  modport master (output start, nb_lanes, vsew, vl, beat_ready, vmask,
                  input  busy, beat_valid, lane_en, bit_idx, chunk_off, done, err);
  modport slave  (input  start, nb_lanes, vsew, vl, beat_ready, vmask,
                  output busy, beat_valid, lane_en, bit_idx, chunk_off, done, err);
`else
  modport master (output start, nb_lanes, vsew, vl, beat_ready,
                  input  busy, beat_valid, lane_en, bit_idx, chunk_off, done, err);
  modport slave  (input  start, nb_lanes, vsew, vl, beat_ready,
                  output busy, beat_valid, lane_en, bit_idx, chunk_off, done, err);
`endif
endinterface

// File: rtl/vec_lane_sequencer.sv
// Element/beat sequencer for up to MAX_LANES vector ALU lanes; all outputs registered, first beat the cycle after start.
// Beats hold while beat_ready is low; VEC_LANE_SEQ_MASK_EN adds a vmask that skips fully masked lane groups.
module vec_lane_sequencer #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int MAX_LANES  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vec_lane_sequencer_if.slave  bus
);
  localparam int IDXW = $clog2(VLEN);
  localparam int VLW  = $clog2(VLEN / 8) + 1;
  localparam int LNW  = ($clog2(MAX_LANES) + 1 > 1) ? $clog2(MAX_LANES) + 1 : 1;
  localparam int MW   = VLEN / 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [VLW-1:0]            eb_q, eb_d;
  logic [3:0]                chunk_q, chunk_d;
  logic [LNW-1:0]            nbl_q, nbl_d;
  logic [1:0]                sew_q, sew_d;
  logic [VLW-1:0]            vl_q, vl_d;
  logic [MW-1:0]             mask_q, mask_d;
  logic                      busy_q, busy_d, valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic [MAX_LANES-1:0]      lane_en_q, lane_en_d, nxt_en;
  logic [MAX_LANES*IDXW-1:0] bit_idx_q, bit_idx_d;
  logic [3:0]                chunk_off_q, chunk_off_d;

  logic [31:0] in_sew, in_l, cur_sew, cur_l, cur_chunks;
  logic        cfg_ok, last_chunk, last_grp, grp_empty;

  function automatic logic [MAX_LANES-1:0] lanes_of(input logic [VLW-1:0] eb,
      input logic [LNW-1:0] nbl, input logic [VLW-1:0] vl, input logic [MW-1:0] m);
    logic [31:0] l, e;
    lanes_of = '0;
    l = 32'd1 << nbl;
    for (int i = 0; i < MAX_LANES; i++) begin
      e = 32'(eb) + 32'(i);
      lanes_of[i] = (32'(i) < l) && (e < 32'(vl)) && (((m >> e) & MW'(1)) != '0);
    end
  endfunction

  // Offsets wrap modulo the register length by truncation to IDXW bits.
  function automatic logic [MAX_LANES*IDXW-1:0] bits_of(input logic [VLW-1:0] eb,
      input logic [1:0] s, input logic [3:0] ch, input logic [MAX_LANES-1:0] en);
    logic [31:0] sew, e;
    bits_of = '0;
    sew = 32'd8 << s;
    for (int i = 0; i < MAX_LANES; i++) begin
      e = 32'(eb) + 32'(i);
      if (en[i]) bits_of[i*IDXW +: IDXW] = IDXW'(e * sew + (32'(ch) << LANE_WIDTH));
    end
  endfunction

  always_comb begin
    in_sew = 32'd8 << bus.vsew;
    in_l   = 32'd1 << bus.nb_lanes;
    cfg_ok = (bus.vsew <= 3'd3) && (in_sew <= 32'(VLEN)) && (in_l <= 32'(MAX_LANES))
             && (32'(bus.vl) * in_sew <= 32'(VLEN));

    cur_sew    = 32'd8 << sew_q;
    cur_l      = 32'd1 << nbl_q;
    cur_chunks = (cur_sew > (32'd1 << LANE_WIDTH)) ? (cur_sew >> LANE_WIDTH) : 32'd1;
    last_chunk = (32'(chunk_q) + 32'd1 == cur_chunks);
    last_grp   = (32'(eb_q) + cur_l >= 32'(vl_q));
    grp_empty  = ~|lanes_of(eb_q, nbl_q, vl_q, mask_q);

    state_d = state_q;
    eb_d    = eb_q;
    chunk_d = chunk_q;
    nbl_d   = nbl_q;
    sew_d   = sew_q;
    vl_d    = vl_q;
`ifdef VEC_LANE_SEQ_MASK_EN
    mask_d  = mask_q;
`endif
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!cfg_ok) begin
            err_d = 1'b1;
          end else begin
            nbl_d   = bus.nb_lanes;
            sew_d   = bus.vsew[1:0];
            vl_d    = bus.vl;
`ifdef VEC_LANE_SEQ_MASK_EN
            mask_d  = bus.vmask;
`endif
            eb_d    = '0;
            chunk_d = '0;
            state_d = (bus.vl == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        // A fully masked group spends one idle cycle and skips all its chunks.
        if (grp_empty) begin
          chunk_d = '0;
          if (last_grp) state_d = DONE;
          else          eb_d    = eb_q + VLW'(cur_l);
        end else if (bus.beat_ready) begin
          if (last_chunk) begin
            chunk_d = '0;
            if (last_grp) state_d = DONE;
            else          eb_d    = eb_q + VLW'(cur_l);
          end else begin
            chunk_d = chunk_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are derived from next state so every output leaves a flop.
    nxt_en      = lanes_of(eb_d, nbl_d, vl_d, mask_d);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    valid_d     = (state_d == RUN) && (|nxt_en);
    lane_en_d   = valid_d ? nxt_en : '0;
    bit_idx_d   = valid_d ? bits_of(eb_d, sew_d, chunk_d, nxt_en) : '0;
    chunk_off_d = valid_d ? chunk_d : '0;
  end

`ifndef VEC_LANE_SEQ_MASK_EN
  assign mask_q = '1;
  assign mask_d = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      eb_q        <= '0;
      chunk_q     <= '0;
      nbl_q       <= '0;
      sew_q       <= '0;
      vl_q        <= '0;
`ifdef VEC_LANE_SEQ_MASK_EN
      mask_q      <= '0;
`endif
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lane_en_q   <= '0;
      bit_idx_q   <= '0;
      chunk_off_q <= '0;
    end else begin
      state_q     <= state_d;
      eb_q        <= eb_d;
      chunk_q     <= chunk_d;
      nbl_q       <= nbl_d;
      sew_q       <= sew_d;
      vl_q        <= vl_d;
`ifdef VEC_LANE_SEQ_MASK_EN
      mask_q      <= mask_d;
`endif
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      lane_en_q   <= lane_en_d;
      bit_idx_q   <= bit_idx_d;
      chunk_off_q <= chunk_off_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.beat_valid = valid_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.lane_en    = lane_en_q;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.chunk_off  = chunk_off_q;
endmodule
